// File: rtl/bifrost_spi_pkg.sv
// rtl/bifrost_spi_pkg.sv - SPI flash opcodes and save-engine types shared with the boot loader
package bifrost_spi_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RES  = 8'hAB;

  localparam int WIP_BIT = 0;

  typedef enum logic [2:0] {
    s_idle,
    s_wren,
    s_erase,
    s_program,
    s_fetch,
    s_send,
    s_poll,
    s_finish
  } save_state_t;

  // Sub-steps inside a state: issue, wait for the shifter, CS-high gap.
  typedef enum logic [1:0] {
    ph_start,
    ph_wait,
    ph_done,
    ph_gap
  } phase_t;

endpackage

// File: rtl/flash_save_if.sv
// rtl/flash_save_if.sv - SPI flash pins plus shared RAM bus seen by the save engine
interface flash_save_if;

  logic        flash_so;
  logic        flash_si;
  logic        flash_sck;
  logic        flash_cs_n;
  logic [18:0] address;
  logic [7:0]  data;
  logic        rw;
  logic        busen;

  modport master (
    input  flash_so, data,
    output flash_si, flash_sck, flash_cs_n, address, rw, busen
  );

  modport slave (
    output flash_so, data,
    input  flash_si, flash_sck, flash_cs_n, address, rw, busen
  );

endinterface

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - MSB-first SPI mode-0 shifter, SCK = clock/2, up to 32 bits per load
module spi_shift (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [5:0]  load_bits,
  input  logic        so,
  output logic        si,
  output logic        sck,
  output logic        busy,
  output logic [7:0]  rx_byte
);

  logic [31:0] shreg;
  logic [5:0]  bits_left;

  // load_data is left-aligned: bit 31 goes out first.
  assign si = busy & shreg[31];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bits_left <= '0;
      sck       <= 1'b0;
      busy      <= 1'b0;
      rx_byte   <= '0;
    end else if (load) begin
      shreg     <= load_data;
      bits_left <= load_bits;
      sck       <= 1'b0;
      busy      <= (load_bits != 6'd0);
    end else if (busy) begin
      if (!sck) begin
        sck <= 1'b1;
      end else begin
        // SO is captured on the same edge that drops SCK.
        sck       <= 1'b0;
        rx_byte   <= {rx_byte[6:0], so};
        shreg     <= {shreg[30:0], 1'b0};
        bits_left <= bits_left - 6'd1;
        if (bits_left == 6'd1) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flash_save.sv
// rtl/flash_save.sv - copies a RAM region into SPI EEPROM/flash with erase, page program and WIP polling
module flash_save
  import bifrost_spi_pkg::*;
#(
  parameter int          EEPROM_ADDRESS_BITS = 24,
  parameter logic [23:0] FLASH_BASE          = 24'h080000,
  parameter logic [18:0] RAM_BASE            = 19'h0F000,
  parameter int          LENGTH              = 4096,
  parameter int          PAGE_SIZE           = 256,
  parameter int          ERASE_SIZE          = 4096,
  parameter logic [7:0]  ERASE_CMD           = 8'h20,
  parameter int          POLL_LIMIT          = 65535
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  flash_save_if.master bus
);

  localparam int              AB         = EEPROM_ADDRESS_BITS;
  localparam int              CMD_BITS   = 8 + AB;
  localparam logic [AB-1:0]   PAGE_MASK  = AB'(PAGE_SIZE - 1);
  localparam logic [AB-1:0]   ERASE_MASK = (ERASE_SIZE > 0) ? AB'(ERASE_SIZE - 1) : '0;
  localparam logic [15:0]     LEN        = 16'(LENGTH);
  localparam logic [15:0]     POLL_LAST  = 16'(POLL_LIMIT - 1);

  save_state_t   state, state_n;
  phase_t        phase, phase_n;
  logic          cs_n_r, cs_n_n;
  logic          busy_n, done_n, error_n, busen_r, busen_n;
  logic [18:0]   address_r, address_n;
  logic [15:0]   byte_cnt, byte_cnt_n;
  logic [AB-1:0] flash_addr, flash_addr_n;
  logic [18:0]   ram_addr, ram_addr_n;
  logic [15:0]   poll_cnt, poll_cnt_n;
  logic [7:0]    data_byte, data_byte_n;
  logic          erase_done, erase_done_n;
  logic          go_finish;
  logic          need_erase;
  logic [AB-1:0] flash_addr_inc;
  logic [15:0]   byte_cnt_inc;

  logic          sh_load;
  logic [31:0]   sh_data;
  logic [5:0]    sh_bits;
  logic          sh_si, sh_sck, sh_busy;
  logic [7:0]    sh_rx;

  function automatic logic [31:0] cmd_word(input logic [7:0] op, input logic [AB-1:0] addr);
    logic [CMD_BITS-1:0] w;
    w = {op, addr};
    return 32'(w) << (32 - CMD_BITS);
  endfunction

  spi_shift u_shift (
    .clock     (clock),
    .reset     (reset),
    .load      (sh_load),
    .load_data (sh_data),
    .load_bits (sh_bits),
    .so        (bus.flash_so),
    .si        (sh_si),
    .sck       (sh_sck),
    .busy      (sh_busy),
    .rx_byte   (sh_rx)
  );

  assign bus.flash_si   = sh_si;
  assign bus.flash_sck  = sh_sck;
  assign bus.flash_cs_n = cs_n_r;
  assign bus.address    = address_r;
  assign bus.rw         = 1'b1;
  assign bus.busen      = busen_r;

  assign flash_addr_inc = flash_addr + AB'(1);
  assign byte_cnt_inc   = byte_cnt + 16'd1;
  // The first block is erased even when FLASH_BASE sits mid-block.
  assign need_erase     = (ERASE_SIZE > 0) && !erase_done &&
                          ((byte_cnt == 16'd0) || ((flash_addr & ERASE_MASK) == '0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= s_idle;
      phase      <= ph_start;
      cs_n_r     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      busen_r    <= 1'b1;
      address_r  <= '0;
      byte_cnt   <= '0;
      flash_addr <= '0;
      ram_addr   <= '0;
      poll_cnt   <= '0;
      data_byte  <= '0;
      erase_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cs_n_r     <= cs_n_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
      busen_r    <= busen_n;
      address_r  <= address_n;
      byte_cnt   <= byte_cnt_n;
      flash_addr <= flash_addr_n;
      ram_addr   <= ram_addr_n;
      poll_cnt   <= poll_cnt_n;
      data_byte  <= data_byte_n;
      erase_done <= erase_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    cs_n_n       = cs_n_r;
    busy_n       = busy;
    done_n       = 1'b0;
    error_n      = error;
    busen_n      = busen_r;
    address_n    = address_r;
    byte_cnt_n   = byte_cnt;
    flash_addr_n = flash_addr;
    ram_addr_n   = ram_addr;
    poll_cnt_n   = poll_cnt;
    data_byte_n  = data_byte;
    erase_done_n = erase_done;
    go_finish    = 1'b0;
    sh_load      = 1'b0;
    sh_data      = '0;
    sh_bits      = '0;

    case (state)
      s_idle: begin
        if (start) begin
          busy_n       = 1'b1;
          busen_n      = 1'b0;
          error_n      = 1'b0;
          byte_cnt_n   = '0;
          flash_addr_n = AB'(FLASH_BASE);
          ram_addr_n   = RAM_BASE;
          poll_cnt_n   = '0;
          erase_done_n = 1'b0;
          state_n      = s_wren;
          phase_n      = ph_start;
        end
      end

      s_wren: begin
        case (phase)
          ph_start: begin
            cs_n_n     = 1'b0;
            sh_load    = 1'b1;
            sh_data    = {OP_WREN, 24'h0};
            sh_bits    = 6'd8;
            poll_cnt_n = '0;
            phase_n    = ph_wait;
          end
          ph_wait: if (!sh_busy) begin
            cs_n_n  = 1'b1;
            phase_n = ph_gap;
            state_n = need_erase ? s_erase : s_program;
          end
          default: phase_n = ph_start;
        endcase
      end

      s_erase: begin
        case (phase)
          ph_start: begin
            cs_n_n       = 1'b0;
            sh_load      = 1'b1;
            sh_data      = cmd_word(ERASE_CMD, flash_addr);
            sh_bits      = 6'(CMD_BITS);
            erase_done_n = 1'b1;
            phase_n      = ph_wait;
          end
          ph_wait: if (!sh_busy) begin
            cs_n_n  = 1'b1;
            phase_n = ph_gap;
            state_n = s_poll;
          end
          default: phase_n = ph_start;
        endcase
      end

      s_program: begin
        case (phase)
          ph_start: begin
            cs_n_n       = 1'b0;
            sh_load      = 1'b1;
            sh_data      = cmd_word(OP_PP, flash_addr);
            sh_bits      = 6'(CMD_BITS);
            erase_done_n = 1'b0;
            phase_n      = ph_wait;
          end
          ph_wait: if (!sh_busy) begin
            state_n = s_fetch;
            phase_n = ph_start;
          end
          default: phase_n = ph_start;
        endcase
      end

      s_fetch: begin
        // Address out, one clock for the RAM, then capture.
        case (phase)
          ph_start: begin
            address_n = ram_addr;
            phase_n   = ph_wait;
          end
          ph_wait: phase_n = ph_done;
          ph_done: begin
            data_byte_n = bus.data;
            state_n     = s_send;
            phase_n     = ph_start;
          end
          default: phase_n = ph_start;
        endcase
      end

      s_send: begin
        case (phase)
          ph_start: begin
            sh_load = 1'b1;
            sh_data = {data_byte, 24'h0};
            sh_bits = 6'd8;
            phase_n = ph_wait;
          end
          ph_wait: if (!sh_busy) begin
            byte_cnt_n   = byte_cnt_inc;
            flash_addr_n = flash_addr_inc;
            ram_addr_n   = ram_addr + 19'd1;
            if ((byte_cnt_inc == LEN) || ((flash_addr_inc & PAGE_MASK) == '0)) begin
              cs_n_n  = 1'b1;
              state_n = s_poll;
              phase_n = ph_gap;
            end else begin
              state_n = s_fetch;
              phase_n = ph_start;
            end
          end
          default: phase_n = ph_start;
        endcase
      end

      s_poll: begin
        case (phase)
          ph_start: begin
            cs_n_n  = 1'b0;
            sh_load = 1'b1;
            sh_data = {OP_RDSR, 24'h0};
            sh_bits = 6'd16;
            phase_n = ph_wait;
          end
          ph_wait: if (!sh_busy) begin
            cs_n_n  = 1'b1;
            phase_n = ph_gap;
            if (!sh_rx[WIP_BIT]) begin
              poll_cnt_n = '0;
              if (byte_cnt == LEN) go_finish = 1'b1;
              else state_n = s_wren;
            end else if (poll_cnt == POLL_LAST) begin
              error_n   = 1'b1;
              go_finish = 1'b1;
            end else begin
              poll_cnt_n = poll_cnt + 16'd1;
            end
          end
          default: phase_n = ph_start;
        endcase
      end

      s_finish: begin
        state_n = s_idle;
        phase_n = ph_start;
      end

      default: state_n = s_idle;
    endcase

    if (go_finish) begin
      state_n   = s_finish;
      phase_n   = ph_start;
      cs_n_n    = 1'b1;
      done_n    = 1'b1;
      busy_n    = 1'b0;
      busen_n   = 1'b1;
      address_n = '0;
    end
  end

endmodule

// File: tb/tb_flash_save.sv
// tb/tb_flash_save.sv - directed bench: three flash_save instances against a 25AA512-style SPI model
module tb_flash_save;

  logic       clock;
  logic       reset;
  logic [2:0] start_v;
  logic [2:0] busy_v, done_v, error_v;
  logic [2:0] clr_v;

  int  n_checks;
  int  n_fail;
  bit  ok;
  int  errs;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instance 0: aligned 256-byte copy, 1: unaligned 4 bytes, 2: WIP stuck with POLL_LIMIT=3.
  for (genvar k = 0; k < 3; k++) begin : g
    flash_save_if bus ();

    flash_save #(
      .EEPROM_ADDRESS_BITS (16),
      .FLASH_BASE          ((k == 1) ? 24'h00E07E : 24'h00E000),
      .RAM_BASE            (19'h0F000),
      .LENGTH              ((k == 0) ? 256 : 4),
      .PAGE_SIZE           (128),
      .ERASE_SIZE          (0),
      .ERASE_CMD           (8'h20),
      .POLL_LIMIT          ((k == 2) ? 3 : 65535)
    ) dut (
      .clock (clock),
      .reset (reset),
      .start (start_v[k]),
      .busy  (busy_v[k]),
      .done  (done_v[k]),
      .error (error_v[k]),
      .bus   (bus)
    );

    logic [7:0]  mem [0:65535];
    logic [7:0]  sh;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] pa;
    logic        wel;
    logic        so;
    logic        wip;
    int          bits, wren_cnt, pp_cnt, rdsr_cnt, wip_cnt, data_cnt;
    logic [15:0] pp_addr [4];
    int          pp_len [4];

    always @(posedge clock) bus.data <= bus.address[7:0] ^ 8'h5A;

    assign wip = (k == 2) ? 1'b1 : (wip_cnt > 0);
    assign bus.flash_so = so;

    always @(posedge bus.flash_sck or posedge bus.flash_cs_n or posedge clr_v[k]) begin
      if (clr_v[k]) begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
        bits = 0; wren_cnt = 0; pp_cnt = 0; rdsr_cnt = 0; wip_cnt = 0; data_cnt = 0;
        cmd = 8'h00; addr = 16'h0; pa = 16'h0; wel = 1'b0; sh = 8'h00;
        for (int i = 0; i < 4; i++) begin pp_addr[i] = 16'h0; pp_len[i] = 0; end
      end else if (bus.flash_cs_n) begin
        if (cmd == 8'h06 && bits == 8) begin wel = 1'b1; wren_cnt++; end
        if (cmd == 8'h02 && bits >= 24) begin
          if (pp_cnt < 4) begin pp_addr[pp_cnt] = pa; pp_len[pp_cnt] = data_cnt; end
          pp_cnt++;
          wel = 1'b0;
          wip_cnt = 2;
        end
        if (cmd == 8'h05 && bits >= 16) begin
          rdsr_cnt++;
          if (wip_cnt > 0) wip_cnt--;
        end
        bits = 0; cmd = 8'h00; data_cnt = 0;
      end else begin
        sh = {sh[6:0], bus.flash_si};
        bits++;
        if (bits % 8 == 0) begin
          case (bits / 8)
            1: cmd = sh;
            2: addr[15:8] = sh;
            3: begin addr[7:0] = sh; pa = {addr[15:8], sh}; end
            default: if (cmd == 8'h02) begin
              if (wel) mem[addr] = sh;
              addr[6:0] = addr[6:0] + 7'd1;
              data_cnt++;
            end
          endcase
        end
      end
    end

    // Status byte {7'b0, WIP} follows the RDSR opcode, shifted out on SCK falls.
    always @(negedge bus.flash_sck or posedge bus.flash_cs_n) begin
      if (bus.flash_cs_n) so = 1'b0;
      else if (cmd == 8'h05 && bits == 15) so = wip;
      else so = 1'b0;
    end

    int   busen_viol, idle_viol, gap_viol, done_cnt, gap;
    logic prev_cs;

    always @(negedge clock) begin
      if (clr_v[k]) begin
        busen_viol = 0; idle_viol = 0; gap_viol = 0; done_cnt = 0; gap = 2; prev_cs = 1'b1;
      end else begin
        if (busy_v[k] && bus.busen) busen_viol++;
        if (bus.flash_cs_n && (bus.flash_sck || bus.flash_si)) idle_viol++;
        if (done_v[k]) done_cnt++;
        if (!bus.flash_cs_n && bus.flash_sck && prev_cs) gap_viol++;
        if (bus.flash_cs_n) gap++;
        else begin
          if (prev_cs && gap < 2) gap_viol++;
          gap = 0;
        end
        prev_cs = bus.flash_cs_n;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int k, input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      @(negedge clock);
      if (done_v[k]) seen = 1'b1;
    end
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(negedge clock);
    start_v[k] = 1'b0;
  endtask

  task automatic clear_models();
    @(posedge clock);
    clr_v = 3'b111;
    @(posedge clock);
    clr_v = 3'b000;
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    start_v  = 3'b000;
    clr_v    = 3'b000;
    repeat (3) @(negedge clock);

    check_eq("rst_busy",    busy_v[0], 1'b0);
    check_eq("rst_done",    done_v[0], 1'b0);
    check_eq("rst_error",   error_v[0], 1'b0);
    check_eq("rst_cs_n",    g[0].bus.flash_cs_n, 1'b1);
    check_eq("rst_sck",     g[0].bus.flash_sck, 1'b0);
    check_eq("rst_si",      g[0].bus.flash_si, 1'b0);
    check_eq("rst_address", g[0].bus.address, 19'h0);
    check_eq("rst_rw",      g[0].bus.rw, 1'b1);
    check_eq("rst_busen",   g[0].bus.busen, 1'b1);

    clear_models();
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Aligned 256-byte copy with a stray start mid-run.
    pulse_start(0);
    check_eq("a_busy_after_start",  busy_v[0], 1'b1);
    check_eq("a_busen_after_start", g[0].bus.busen, 1'b0);
    repeat (300) @(negedge clock);
    pulse_start(0);
    wait_done(0, 20000, ok);
    check_eq("a_done_seen",   ok, 1'b1);
    check_eq("a_done_error",  error_v[0], 1'b0);
    check_eq("a_done_busy",   busy_v[0], 1'b0);
    check_eq("a_done_busen",  g[0].bus.busen, 1'b1);
    check_eq("a_done_cs_n",   g[0].bus.flash_cs_n, 1'b1);
    repeat (20) @(negedge clock);
    check_eq("a_done_count",  g[0].done_cnt, 1);
    check_eq("a_busy_idle",   busy_v[0], 1'b0);
    check_eq("a_pp_count",    g[0].pp_cnt, 2);
    check_eq("a_pp0_addr",    g[0].pp_addr[0], 16'hE000);
    check_eq("a_pp0_len",     g[0].pp_len[0], 128);
    check_eq("a_pp1_addr",    g[0].pp_addr[1], 16'hE080);
    check_eq("a_pp1_len",     g[0].pp_len[1], 128);
    check_eq("a_wren_count",  g[0].wren_cnt, 2);
    check_eq("a_rdsr_count",  g[0].rdsr_cnt, 6);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (g[0].mem[16'hE000 + i] !== (8'(i) ^ 8'h5A)) errs++;
    check_eq("a_mem_mismatches", errs, 0);
    check_eq("a_busen_viol",  g[0].busen_viol, 0);
    check_eq("a_idle_viol",   g[0].idle_viol, 0);
    check_eq("a_cs_gap_viol", g[0].gap_viol, 0);

    // Unaligned base: short first page, then a fresh WREN+PP.
    pulse_start(1);
    wait_done(1, 5000, ok);
    check_eq("b_done_seen",   ok, 1'b1);
    check_eq("b_done_error",  error_v[1], 1'b0);
    repeat (5) @(negedge clock);
    check_eq("b_pp_count",    g[1].pp_cnt, 2);
    check_eq("b_pp0_addr",    g[1].pp_addr[0], 16'hE07E);
    check_eq("b_pp0_len",     g[1].pp_len[0], 2);
    check_eq("b_pp1_addr",    g[1].pp_addr[1], 16'hE080);
    check_eq("b_pp1_len",     g[1].pp_len[1], 2);
    check_eq("b_wren_count",  g[1].wren_cnt, 2);
    check_eq("b_mem_e07e",    g[1].mem[16'hE07E], 8'h5A);
    check_eq("b_mem_e07f",    g[1].mem[16'hE07F], 8'h5B);
    check_eq("b_mem_e080",    g[1].mem[16'hE080], 8'h58);
    check_eq("b_mem_e081",    g[1].mem[16'hE081], 8'h59);
    check_eq("b_done_count",  g[1].done_cnt, 1);
    check_eq("b_cs_gap_viol", g[1].gap_viol, 0);

    // WIP never clears: third busy status read aborts with error.
    pulse_start(2);
    wait_done(2, 5000, ok);
    check_eq("c_done_seen",   ok, 1'b1);
    check_eq("c_done_error",  error_v[2], 1'b1);
    check_eq("c_done_cs_n",   g[2].bus.flash_cs_n, 1'b1);
    check_eq("c_done_busen",  g[2].bus.busen, 1'b1);
    check_eq("c_done_busy",   busy_v[2], 1'b0);
    repeat (5) @(negedge clock);
    check_eq("c_rdsr_count",  g[2].rdsr_cnt, 3);
    check_eq("c_pp_count",    g[2].pp_cnt, 1);
    check_eq("c_error_held",  error_v[2], 1'b1);
    check_eq("c_done_count",  g[2].done_cnt, 1);

    // Reset in the middle of the fifth data byte.
    clear_models();
    pulse_start(0);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge clock);
      if (g[0].cmd == 8'h02 && g[0].bits >= 60) ok = 1'b1;
    end
    check_eq("r_reached_byte5", ok, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("r_cs_n",  g[0].bus.flash_cs_n, 1'b1);
    check_eq("r_sck",   g[0].bus.flash_sck, 1'b0);
    check_eq("r_busy",  busy_v[0], 1'b0);
    check_eq("r_busen", g[0].bus.busen, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_models();
    pulse_start(0);
    wait_done(0, 20000, ok);
    check_eq("r2_done_seen",  ok, 1'b1);
    check_eq("r2_done_error", error_v[0], 1'b0);
    repeat (5) @(negedge clock);
    check_eq("r2_pp_count",   g[0].pp_cnt, 2);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (g[0].mem[16'hE000 + i] !== (8'(i) ^ 8'h5A)) errs++;
    check_eq("r2_mem_mismatches", errs, 0);
    check_eq("r2_done_count", g[0].done_cnt, 1);
    check_eq("r2_busen_viol", g[0].busen_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_save.md
Name: flash_save

Overview:
- Counterpart to the power-on boot loader: copies a RAM region out to the SPI EEPROM/flash, so a CPU-edited boot image persists across power cycles.
- Runs on a one-cycle `start` pulse while the 6502 is held off the bus.
- Reads RAM through the shared 19-bit bus and acts as SPI master, mode 0, SCK = clock/2.
- Per programming page: optional erase at each erase-block boundary, then WREN, PAGE PROGRAM, and RDSR polling until WIP clears.

Parameters:
- EEPROM_ADDRESS_BITS, 24, flash address width sent after each command (24 or 16).
- FLASH_BASE, 24'h080000, first flash byte address written.
- RAM_BASE, 19'h0F000, first RAM byte address read.
- LENGTH, 4096, bytes copied (1..65535).
- PAGE_SIZE, 256, flash program page (power of 2).
- ERASE_SIZE, 4096, erase block (power of 2, multiple of PAGE_SIZE); 0 disables erase.
- ERASE_CMD, 8'h20, erase opcode.
- POLL_LIMIT, 65535, max RDSR reads per busy wait before error.

Ports:
- clock  in  1  system clock (8 MHz).
- reset  in  1  asynchronous, active-low; LOW forces reset state immediately.
- start  in  1  one-cycle request; ignored unless idle.
- busy  out  1  HIGH from cycle after accepted start until done.
- done  out  1  one-cycle pulse at completion or abort.
- error  out  1  set with done on poll timeout; cleared by next accepted start.
- flash_so  in  1  SPI MISO.
- flash_si  out  1  SPI MOSI.
- flash_sck  out  1  SPI clock.
- flash_cs_n  out  1  SPI chip select, active-low.
- address  out  19  RAM address.
- data  in  8  RAM read data, valid one clock after address changes.
- rw  out  1  bus read/write; held HIGH (read only).
- busen  out  1  HIGH = 6502 bus enabled; LOW while busy.

Behaviour:
- Reset values: busy=0, done=0, error=0, flash_si=0, flash_sck=0, flash_cs_n=1, address=0, rw=1, busen=1, state=s_idle, all counters 0.
- SPI shifter:
  - Loaded with up to 32 bits plus a bit count; MSB first.
  - Per bit: SCK-low clock with SI presented, then SCK-high clock.
  - SO is sampled on the clock edge that drives SCK 1->0.
  - SCK rests low; SI rests 0 when not shifting.
- Chip select:
  - CS_n falls at least one clock before the first SCK rise.
  - CS_n rises one clock after the last SCK fall.
  - CS_n stays high at least 2 clocks between commands.
- States:
  - s_idle: on start, set busy=1, busen=0, clear error; load byte counter=0, flash addr=FLASH_BASE, RAM addr=RAM_BASE. -> s_wren.
  - s_wren: send 0x06, release CS. -> s_erase if ERASE_SIZE>0 and flash addr is ERASE_SIZE-aligned (or this is the first block), else s_program.
  - s_erase: send ERASE_CMD + address, release CS. -> s_poll, then s_wren (the program phase needs a fresh WREN).
  - s_program: send 0x02 + address, keep CS low. -> s_fetch.
  - s_fetch: drive address=RAM addr, wait one clock, latch data. -> s_send.
  - s_send: shift 8 bits, increment counters.
    - If LENGTH is reached or the next flash addr is PAGE_SIZE-aligned: release CS, -> s_poll.
    - Else -> s_fetch.
  - s_poll: send 0x05 and read 8 bits, release CS.
    - If bit0 (WIP) = 0: -> s_wren if bytes remain, else s_finish.
    - Else repeat. On the POLL_LIMIT-th busy read: error=1, -> s_finish.
  - s_finish: CS_n=1, SCK=0, address=0, busen=1, busy=0, done=1 for one clock. -> s_idle.
- Arithmetic: flash address wraps modulo 2^EEPROM_ADDRESS_BITS; RAM address wraps modulo 2^19; no fault is raised on wrap.
- A page split happens only at PAGE_SIZE alignment; an unaligned FLASH_BASE yields a short first page.
- Erase runs only when entering a new erase block. A partially covered first block is still erased whole; this is acceptable and documented.
- Reset mid-operation: outputs return to reset values asynchronously. The flash may be left partially erased or programmed; no recovery is attempted.
- start while busy is ignored; no queueing.

Decomposition:
- Shared package `bifrost_spi_pkg` holds opcodes (READ 0x03, WREN 0x06, PP 0x02, RDSR 0x05, RES 0xAB) and the WIP bit index, shared with the boot loader.
- Natural sub-module: `spi_shift`, the MSB-first mode-0 shifter with load/count/busy and the captured read byte. It is reusable later to refactor the boot loader.

Test Plan:
- 25AA512 model, EEPROM_ADDRESS_BITS=16, FLASH_BASE=16'hE000, PAGE_SIZE=128, ERASE_SIZE=0, LENGTH=256, RAM 0x0F000.. filled with i^8'h5A. Pulse start -> two PP commands at 0xE000 and 0xE080; model contents match; done pulses once; error=0; busen LOW throughout busy.
- Boot-loader round trip: run flash_save, reset the system, run the boot loader -> RAM 0x0F000..0x0F0FF re-read identically.
- Unaligned: FLASH_BASE=16'hE07E, LENGTH=4 -> PP of 2 bytes at 0xE07E, then a separate WREN+PP of 2 bytes at 0xE080.
- Status stub with WIP stuck 1, POLL_LIMIT=3 -> exactly 3 RDSR commands, then done=1 and error=1, CS_n=1, busen=1.
- Assert reset LOW during the 5th data byte -> same clock: CS_n=1, SCK=0, busy=0, busen=1. After release, start runs a clean full copy.
- Extra start pulses while busy -> no effect; exactly one done pulse per accepted start.
